cpu_wb_master: RTL and testbench
================================

Name: cpu_wb_master

Overview:
- Wishbone master bridge between the MiniMIPS32 pipeline memory port (instruction or data side) and the shared Wishbone bus.
- The BRAM slave and other slaves sit downstream of this block.
- Converts single-cycle CPU memory requests into Wishbone classic cycles.
- Holds the pipeline via a stall request until the cycle terminates, and buffers read data when the pipeline is frozen by another stage.
- Guards against hung slaves with an ack timeout.

Parameters:
- TIMEOUT, 255: max cycles BUSY waits for wb_ack_i before aborting. Must be 1..255.
- CNT_W, 8: width of the timeout counter. Must satisfy 2^CNT_W > TIMEOUT.

Ports:
- wb_clk_i  in  1  clock, rising edge
- wb_rst_i  in  1  asynchronous reset, active-high
- cpu_ce_i  in  1  CPU request valid
- cpu_we_i  in  1  1=store, 0=load
- cpu_addr_i  in  32  byte address
- cpu_sel_i  in  4  byte lane enables
- cpu_data_i  in  32  store data
- cpu_data_o  out  32  load data to pipeline
- stall_i  in  1  pipeline stalled by another source (stall from other stages)
- flush_i  in  1  pipeline flush (exception/eret)
- stall_req_o  out  1  stall request to pipeline control
- err_o  out  1  one-cycle pulse on timeout abort
- wb_cyc_o  out  1  Wishbone cycle
- wb_stb_o  out  1  Wishbone strobe
- wb_we_o  out  1  Wishbone write enable
- wb_adr_o  out  32  Wishbone address
- wb_dat_o  out  32  Wishbone write data
- wb_sel_o  out  4  Wishbone byte select
- wb_dat_i  in  32  Wishbone read data
- wb_ack_i  in  1  Wishbone acknowledge

Behaviour:
- Reset (async, wb_rst_i=1):
  - state=IDLE; cnt=0; rd_buf=0.
  - wb_cyc_o/wb_stb_o/wb_we_o=0; wb_adr_o=0; wb_dat_o=0; wb_sel_o=0.
  - err_o=0.
  - stall_req_o=0 and cpu_data_o=0 while reset is held.
- All Wishbone outputs are registered. stall_req_o and cpu_data_o are combinational from state and inputs.
- IDLE:
  - If cpu_ce_i=1 and flush_i=0: register cyc=stb=1, we=cpu_we_i, adr=cpu_addr_i, dat=cpu_data_i, sel=cpu_sel_i; cnt<=0; go to BUSY.
  - stall_req_o = cpu_ce_i & ~flush_i.
  - cpu_data_o=0.
- BUSY:
  - Wishbone outputs are held constant.
  - On wb_ack_i=1:
    - cyc/stb/we<=0, sel<=0.
    - rd_buf<=wb_dat_i on a load; rd_buf unchanged on a store.
    - stall_req_o=0 in this cycle.
    - cpu_data_o=wb_dat_i (load) or 0 (store) in this cycle.
    - Next state is WAIT_STALL if stall_i=1, else IDLE.
  - Without ack:
    - stall_req_o=1; cnt<=cnt+1.
    - When cnt==TIMEOUT-1 and no ack: cyc/stb/we/sel<=0; err_o<=1 for exactly one cycle; rd_buf<=0; go to IDLE. stall_req_o stays 1 in this cycle.
- WAIT_STALL:
  - stall_req_o=0; cpu_data_o=rd_buf.
  - Return to IDLE in the first cycle with stall_i=0. A new request is not accepted in that same cycle.
- flush_i:
  - In BUSY, flush_i=1 has priority over ack and timeout: terminate the cycle (outputs<=0), discard data, go to IDLE. stall_req_o=0 in that cycle.
  - In WAIT_STALL, flush_i=1 goes to IDLE.
- Latency against a combinational-ack slave (ack = cyc & stb):
  - Request sampled at edge N; cyc/stb visible in cycle N+1; ack and data in cycle N+1.
  - stall_req_o is high for exactly one cycle: the request cycle.
- Back-to-back:
  - A new request is accepted in IDLE only.
  - The cycle after ack is always IDLE or WAIT_STALL, so at least one idle bus cycle separates transactions.
- Simultaneous events:
  - err_o and ack never both take effect in one cycle; ack wins over timeout.
  - Reset mid-cycle drops cyc/stb immediately (asynchronous).

Test Plan:
- Load, ack 1 cycle after cyc (BRAM-like slave), cpu_addr_i=0x0000_0010, wb_dat_i=0xDEADBEEF, stall_i=0:
  - cyc/stb high exactly 1 cycle with wb_adr_o=0x10, wb_we_o=0.
  - stall_req_o high 1 cycle.
  - cpu_data_o=0xDEADBEEF in the ack cycle.
  - err_o=0.
- Store, sel=4'b0011, data=0x12345678, slave acks after 3 wait cycles:
  - wb_we_o=1, wb_sel_o=0011, wb_dat_o=0x12345678 stable for 4 cycles.
  - stall_req_o high for 4 cycles, then low.
- Load acked while stall_i=1 for 3 cycles, wb_dat_i=0xA5A5A5A5:
  - state goes to WAIT_STALL.
  - cpu_data_o holds 0xA5A5A5A5 until stall_i falls.
  - Then IDLE, cpu_data_o=0.
- TIMEOUT=4, slave never acks:
  - cyc drops after 4 BUSY cycles; err_o pulses exactly 1 cycle.
  - Next cycle is IDLE with stall_req_o=0 when cpu_ce_i=0.
- flush_i=1 in the same cycle as ack:
  - Data discarded, rd_buf unchanged, cyc<=0, state IDLE, err_o=0.
- wb_rst_i asserted mid-BUSY (asynchronously, between clock edges):
  - wb_cyc_o/wb_stb_o drop to 0 immediately without a clock edge.
  - After release, a new load completes normally.

Source files
------------

// File: rtl/cpu_wb_master.sv
// Wishbone classic master bridging a MiniMIPS32 memory port onto the shared bus.
// Stalls the pipeline while a cycle is open, buffers load data across external stalls, aborts hung cycles.
module cpu_wb_master #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        cpu_ce_i,
    input  logic        cpu_we_i,
    input  logic [31:0] cpu_addr_i,
    input  logic [3:0]  cpu_sel_i,
    input  logic [31:0] cpu_data_i,
    output logic [31:0] cpu_data_o,
    input  logic        stall_i,
    input  logic        flush_i,
    output logic        stall_req_o,
    output logic        err_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic [3:0]  wb_sel_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i
);

    typedef enum logic [1:0] {IDLE, BUSY, WAIT_STALL} state_t;

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [31:0]        rd_buf_reg, rd_buf_next;
    logic               cyc_reg, cyc_next;
    logic               we_reg, we_next;
    logic [31:0]        adr_reg, adr_next;
    logic [31:0]        dat_reg, dat_next;
    logic [3:0]         sel_reg, sel_next;
    logic               err_reg, err_next;
    logic               stall_req;
    logic [31:0]        cpu_data;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            rd_buf_reg <= '0;
            cyc_reg    <= 1'b0;
            we_reg     <= 1'b0;
            adr_reg    <= '0;
            dat_reg    <= '0;
            sel_reg    <= '0;
            err_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            rd_buf_reg <= rd_buf_next;
            cyc_reg    <= cyc_next;
            we_reg     <= we_next;
            adr_reg    <= adr_next;
            dat_reg    <= dat_next;
            sel_reg    <= sel_next;
            err_reg    <= err_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        rd_buf_next = rd_buf_reg;
        cyc_next    = cyc_reg;
        we_next     = we_reg;
        adr_next    = adr_reg;
        dat_next    = dat_reg;
        sel_next    = sel_reg;
        err_next    = 1'b0;
        stall_req   = 1'b0;
        cpu_data    = '0;

        case (state_reg)
            IDLE: begin
                stall_req = cpu_ce_i & ~flush_i;
                if (cpu_ce_i && !flush_i) begin
                    cyc_next   = 1'b1;
                    we_next    = cpu_we_i;
                    adr_next   = cpu_addr_i;
                    dat_next   = cpu_data_i;
                    sel_next   = cpu_sel_i;
                    cnt_next   = '0;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                // Priority: flush, then ack, then timeout.
                if (flush_i) begin
                    cyc_next   = 1'b0;
                    we_next    = 1'b0;
                    adr_next   = '0;
                    dat_next   = '0;
                    sel_next   = '0;
                    state_next = IDLE;
                end else if (wb_ack_i) begin
                    cyc_next = 1'b0;
                    we_next  = 1'b0;
                    sel_next = '0;
                    if (!we_reg) begin
                        rd_buf_next = wb_dat_i;
                        cpu_data    = wb_dat_i;
                    end
                    state_next = stall_i ? WAIT_STALL : IDLE;
                end else begin
                    stall_req = 1'b1;
                    cnt_next  = cnt_reg + 1'b1;
                    if (cnt_reg == CNT_W'(TIMEOUT - 1)) begin
                        cyc_next    = 1'b0;
                        we_next     = 1'b0;
                        sel_next    = '0;
                        err_next    = 1'b1;
                        rd_buf_next = '0;
                        state_next  = IDLE;
                    end
                end
            end
            WAIT_STALL: begin
                cpu_data = rd_buf_reg;
                if (flush_i || !stall_i)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // The combinational stall must not leak out while the block is held in reset.
    assign stall_req_o = stall_req & ~wb_rst_i;
    assign cpu_data_o  = cpu_data;
    assign err_o       = err_reg;
    assign wb_cyc_o    = cyc_reg;
    assign wb_stb_o    = cyc_reg;
    assign wb_we_o     = we_reg;
    assign wb_adr_o    = adr_reg;
    assign wb_dat_o    = dat_reg;
    assign wb_sel_o    = sel_reg;

endmodule

// File: tb/tb_cpu_wb_master.sv
// Directed bench for cpu_wb_master: per-cycle vector table plus a hand-written async-reset sequence.
module tb_cpu_wb_master;

    logic        clk, rst;
    logic        ce, we, stall, flush, ack;
    logic [31:0] addr, wdat, rdat;
    logic [3:0]  sel;
    logic [31:0] cpu_data, wb_adr, wb_dat;
    logic        stall_req, err, wb_cyc, wb_stb, wb_we;
    logic [3:0]  wb_sel;

    int checks = 0;
    int errors = 0;

    cpu_wb_master #(.TIMEOUT(4), .CNT_W(3)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .cpu_ce_i(ce), .cpu_we_i(we), .cpu_addr_i(addr), .cpu_sel_i(sel),
        .cpu_data_i(wdat), .cpu_data_o(cpu_data),
        .stall_i(stall), .flush_i(flush), .stall_req_o(stall_req), .err_o(err),
        .wb_cyc_o(wb_cyc), .wb_stb_o(wb_stb), .wb_we_o(wb_we), .wb_adr_o(wb_adr),
        .wb_dat_o(wb_dat), .wb_sel_o(wb_sel), .wb_dat_i(rdat), .wb_ack_i(ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        ce, we;
        logic [31:0] addr;
        logic [3:0]  sel;
        logic [31:0] wdat;
        logic        stall, flush, ack;
        logic [31:0] rdat;
        logic        e_cyc, e_we;
        logic [3:0]  e_sel;
        logic [31:0] e_adr, e_wdat;
        logic        e_sr, e_err;
        logic [31:0] e_cpu;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input string nm,
            input logic c, input logic w, input logic [31:0] a, input logic [3:0] s,
            input logic [31:0] wd, input logic st, input logic fl, input logic ak,
            input logic [31:0] rd, input logic ecyc, input logic ewe, input logic [3:0] esel,
            input logic [31:0] eadr, input logic [31:0] ewd, input logic esr,
            input logic eerr, input logic [31:0] ecpu);
        vec_t v;
        v.name = nm; v.ce = c; v.we = w; v.addr = a; v.sel = s; v.wdat = wd;
        v.stall = st; v.flush = fl; v.ack = ak; v.rdat = rd;
        v.e_cyc = ecyc; v.e_we = ewe; v.e_sel = esel; v.e_adr = eadr; v.e_wdat = ewd;
        v.e_sr = esr; v.e_err = eerr; v.e_cpu = ecpu;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        ce = 0; we = 0; addr = 0; sel = 0; wdat = 0;
        stall = 0; flush = 0; ack = 0; rdat = 0;
    endtask

    initial begin
        // name        ce we addr  sel  wdat          st fl ak rdat          cyc we sel  adr   wdat          sr er cpu
        vecs.push_back(mk("ld_req",  1,0,32'h10,4'hF,0,          0,0,0,0,             0,0,4'h0,0,     0,            1,0,0));
        vecs.push_back(mk("ld_ack",  0,0,0,     0,   0,          0,0,1,32'hDEADBEEF,  1,0,4'hF,32'h10,0,            0,0,32'hDEADBEEF));
        vecs.push_back(mk("ld_idle", 0,0,0,     0,   0,          0,0,0,0,             0,0,4'h0,0,     0,            0,0,0));
        vecs.push_back(mk("st_req",  1,1,32'h20,4'h3,32'h12345678,0,0,0,0,            0,0,4'h0,0,     0,            1,0,0));
        vecs.push_back(mk("st_w1",   0,0,0,     0,   0,          0,0,0,0,             1,1,4'h3,32'h20,32'h12345678, 1,0,0));
        vecs.push_back(mk("st_w2",   0,0,0,     0,   0,          0,0,0,0,             1,1,4'h3,32'h20,32'h12345678, 1,0,0));
        vecs.push_back(mk("st_w3",   0,0,0,     0,   0,          0,0,0,0,             1,1,4'h3,32'h20,32'h12345678, 1,0,0));
        vecs.push_back(mk("st_ack",  0,0,0,     0,   0,          0,0,1,32'hFFFFFFFF,  1,1,4'h3,32'h20,32'h12345678, 0,0,0));
        vecs.push_back(mk("st_idle", 0,0,0,     0,   0,          0,0,0,0,             0,0,4'h0,0,     0,            0,0,0));
        vecs.push_back(mk("ws_req",  1,0,32'h30,4'hF,0,          0,0,0,0,             0,0,4'h0,0,     0,            1,0,0));
        vecs.push_back(mk("ws_ack",  0,0,0,     0,   0,          1,0,1,32'hA5A5A5A5,  1,0,4'hF,32'h30,0,            0,0,32'hA5A5A5A5));
        vecs.push_back(mk("ws_hold1",0,0,0,     0,   0,          1,0,0,0,             0,0,4'h0,0,     0,            0,0,32'hA5A5A5A5));
        vecs.push_back(mk("ws_hold2",0,0,0,     0,   0,          1,0,0,0,             0,0,4'h0,0,     0,            0,0,32'hA5A5A5A5));
        vecs.push_back(mk("ws_rel",  1,0,32'h34,4'hF,0,          0,0,0,0,             0,0,4'h0,0,     0,            0,0,32'hA5A5A5A5));
        vecs.push_back(mk("ws_idle", 0,0,0,     0,   0,          0,0,0,0,             0,0,4'h0,0,     0,            0,0,0));
        vecs.push_back(mk("to_req",  1,0,32'h40,4'hF,0,          0,0,0,0,             0,0,4'h0,0,     0,            1,0,0));
        vecs.push_back(mk("to_w0",   0,0,0,     0,   0,          0,0,0,0,             1,0,4'hF,32'h40,0,            1,0,0));
        vecs.push_back(mk("to_w1",   0,0,0,     0,   0,          0,0,0,0,             1,0,4'hF,32'h40,0,            1,0,0));
        vecs.push_back(mk("to_w2",   0,0,0,     0,   0,          0,0,0,0,             1,0,4'hF,32'h40,0,            1,0,0));
        vecs.push_back(mk("to_w3",   0,0,0,     0,   0,          0,0,0,0,             1,0,4'hF,32'h40,0,            1,0,0));
        vecs.push_back(mk("to_err",  0,0,0,     0,   0,          0,0,0,0,             0,0,4'h0,0,     0,            0,1,0));
        vecs.push_back(mk("to_idle", 0,0,0,     0,   0,          0,0,0,0,             0,0,4'h0,0,     0,            0,0,0));
        vecs.push_back(mk("fl_req0", 1,0,32'h50,4'hF,0,          0,0,0,0,             0,0,4'h0,0,     0,            1,0,0));
        vecs.push_back(mk("fl_ack0", 0,0,0,     0,   0,          1,0,1,32'h11111111,  1,0,4'hF,32'h50,0,            0,0,32'h11111111));
        vecs.push_back(mk("fl_rel0", 0,0,0,     0,   0,          0,0,0,0,             0,0,4'h0,0,     0,            0,0,32'h11111111));
        vecs.push_back(mk("fl_req",  1,0,32'h60,4'hF,0,          0,0,0,0,             0,0,4'h0,0,     0,            1,0,0));
        vecs.push_back(mk("fl_ack",  0,0,0,     0,   0,          0,1,1,32'h22222222,  1,0,4'hF,32'h60,0,            0,0,0));
        vecs.push_back(mk("fl_idle", 0,0,0,     0,   0,          0,0,0,0,             0,0,4'h0,0,     0,            0,0,0));
        vecs.push_back(mk("rb_req",  1,1,32'h70,4'hF,32'hCAFEF00D,0,0,0,0,            0,0,4'h0,0,     0,            1,0,0));
        vecs.push_back(mk("rb_ack",  0,0,0,     0,   0,          1,0,1,32'h33333333,  1,1,4'hF,32'h70,32'hCAFEF00D, 0,0,0));
        vecs.push_back(mk("rb_wait", 0,0,0,     0,   0,          0,0,0,0,             0,0,4'h0,0,     0,            0,0,32'h11111111));
        vecs.push_back(mk("rb_idle", 0,0,0,     0,   0,          0,0,0,0,             0,0,4'h0,0,     0,            0,0,0));
        vecs.push_back(mk("fi_req",  1,0,32'h90,4'hF,0,          0,1,0,0,             0,0,4'h0,0,     0,            0,0,0));
        vecs.push_back(mk("fi_idle", 0,0,0,     0,   0,          0,0,0,0,             0,0,4'h0,0,     0,            0,0,0));

        // Reset held with a pending request: everything must stay quiet.
        rst = 1;
        idle_inputs();
        ce = 1; addr = 32'h44; sel = 4'hF;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.cyc", {31'd0, wb_cyc}, 0);
        chk("rst.stb", {31'd0, wb_stb}, 0);
        chk("rst.stall_req", {31'd0, stall_req}, 0);
        chk("rst.adr", wb_adr, 0);
        chk("rst.sel", {28'd0, wb_sel}, 0);
        chk("rst.err", {31'd0, err}, 0);
        chk("rst.cpu_data", cpu_data, 0);
        $display("reset state checked");
        @(negedge clk);
        rst = 0;
        idle_inputs();
        @(posedge clk);
        #1;

        for (int i = 0; i < vecs.size(); i++) begin
            ce = vecs[i].ce; we = vecs[i].we; addr = vecs[i].addr; sel = vecs[i].sel;
            wdat = vecs[i].wdat; stall = vecs[i].stall; flush = vecs[i].flush;
            ack = vecs[i].ack; rdat = vecs[i].rdat;
            @(negedge clk);
            chk({vecs[i].name, ".cyc"}, {31'd0, wb_cyc}, {31'd0, vecs[i].e_cyc});
            chk({vecs[i].name, ".stb"}, {31'd0, wb_stb}, {31'd0, vecs[i].e_cyc});
            chk({vecs[i].name, ".we"}, {31'd0, wb_we}, {31'd0, vecs[i].e_we});
            chk({vecs[i].name, ".sel"}, {28'd0, wb_sel}, {28'd0, vecs[i].e_sel});
            chk({vecs[i].name, ".stall_req"}, {31'd0, stall_req}, {31'd0, vecs[i].e_sr});
            chk({vecs[i].name, ".err"}, {31'd0, err}, {31'd0, vecs[i].e_err});
            chk({vecs[i].name, ".cpu_data"}, cpu_data, vecs[i].e_cpu);
            if (vecs[i].e_cyc) begin
                chk({vecs[i].name, ".adr"}, wb_adr, vecs[i].e_adr);
                chk({vecs[i].name, ".dat"}, wb_dat, vecs[i].e_wdat);
            end
            $display("vec %0d %s cyc=%0b sr=%0b err=%0b cpu=%h", i, vecs[i].name,
                     wb_cyc, stall_req, err, cpu_data);
            @(posedge clk);
            #1;
        end

        // Asynchronous reset in the middle of a BUSY cycle.
        idle_inputs();
        ce = 1; addr = 32'h80; sel = 4'hF;
        @(posedge clk);
        #1;
        idle_inputs();
        chk("arst.busy_cyc", {31'd0, wb_cyc}, 1);
        #2;
        rst = 1;
        #1;
        chk("arst.cyc_drop", {31'd0, wb_cyc}, 0);
        chk("arst.stb_drop", {31'd0, wb_stb}, 0);
        chk("arst.stall_req", {31'd0, stall_req}, 0);
        $display("async reset mid-busy cyc=%0b stb=%0b", wb_cyc, wb_stb);
        @(negedge clk);
        rst = 0;
        @(posedge clk);
        #1;
        ce = 1; addr = 32'h84; sel = 4'hF;
        @(negedge clk);
        chk("arst.req_stall", {31'd0, stall_req}, 1);
        @(posedge clk);
        #1;
        idle_inputs();
        ack = 1; rdat = 32'h5A5A0001;
        @(negedge clk);
        chk("arst.ld_cyc", {31'd0, wb_cyc}, 1);
        chk("arst.ld_adr", wb_adr, 32'h84);
        chk("arst.ld_data", cpu_data, 32'h5A5A0001);
        chk("arst.ld_stall", {31'd0, stall_req}, 0);
        $display("post-reset load cpu_data=%h", cpu_data);
        @(posedge clk);
        #1;
        idle_inputs();
        @(negedge clk);
        chk("arst.done_cyc", {31'd0, wb_cyc}, 0);
        chk("arst.done_err", {31'd0, err}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
